// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern recogniser front end:
// ASCII constants, counter width, output-stage states and a control-byte helper.
package pattern_pkg;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_DEL   = 8'h7F;
    localparam logic [7:0] ASCII_AT    = 8'h40;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;
    localparam logic [7:0] ASCII_DASH  = 8'h2D;
    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_9     = 8'h39;

    localparam int CNT_W = 16;

    typedef enum logic {
        OEMPTY = 1'b0,
        OFULL  = 1'b1
    } out_state_e;

    function automatic logic is_ctrl(input logic [7:0] c);
        return (c < ASCII_SPACE) || (c == ASCII_DEL);
    endfunction

endpackage

// File: rtl/char_fifo_mem.sv
// DEPTH x 8 storage for the feeder FIFO: synchronous write, registered read.
// Ports: clk, rst, wr_en_i/wr_addr_i/wr_data_i, rd_en_i/rd_addr_i, rd_data_o.
module char_fifo_mem #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // Storage array carries no reset; only the read register does.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // The read register doubles as the feeder's output data register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/char_stream_feeder.sv
// Byte feeder ahead of the pattern FSM: optional control-byte filter,
// FIFO buffering and a one-entry output register with valid/ready handshake.
// Ports: in_data/in_valid/in_ready (upstream), out_data/out_valid/ds_ready
// (downstream), flush, level, overflow, accepted_count, dropped_count.
module char_stream_feeder
    import pattern_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int ADDR_W    = 4,
    parameter bit DROP_CTRL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [7:0]        out_data,
    output logic              out_valid,
    input  logic              ds_ready,
    input  logic              flush,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic [CNT_W-1:0]  accepted_count,
    output logic [CNT_W-1:0]  dropped_count
);

    localparam int LW = ADDR_W + 1;
    localparam logic [ADDR_W:0] FULL_LVL = LW'(DEPTH);

    logic [ADDR_W:0]   level_q, level_d;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    out_state_e        state_q;
    logic              out_valid_q;
    logic              overflow_q;
    logic [CNT_W-1:0]  acc_q, drop_q;

    logic full, push_evt, drop_byte, store;
    logic have_data, xfer, pop;

    assign full      = (level_q == FULL_LVL);
    assign push_evt  = in_valid && !full && !flush;
    assign drop_byte = DROP_CTRL && is_ctrl(in_data);
    assign store     = push_evt && !drop_byte;
    assign have_data = (level_q != '0);
    assign xfer      = out_valid_q && ds_ready;

    // Output register refills when empty, or as the current byte leaves.
    assign pop = !flush && have_data && ((state_q == OEMPTY) || xfer);

    assign level_d = level_q + LW'(store) - LW'(pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (store) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
            if (pop)   rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
            level_q <= level_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= OEMPTY;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= OEMPTY;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                OEMPTY: begin
                    if (have_data) begin
                        state_q     <= OFULL;
                        out_valid_q <= 1'b1;
                    end
                end
                OFULL: begin
                    if (xfer && !have_data) begin
                        state_q     <= OEMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= OEMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Overflow and counters survive flush; only reset clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            acc_q      <= '0;
            drop_q     <= '0;
        end else begin
            if (in_valid && full) overflow_q <= 1'b1;
            if (push_evt) begin
                if (drop_byte) begin
                    if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
                end else begin
                    if (acc_q != '1) acc_q <= acc_q + CNT_W'(1);
                end
            end
        end
    end

    char_fifo_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (store),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (in_data),
        .rd_en_i   (pop),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (out_data)
    );

    assign in_ready       = !full;
    assign out_valid      = out_valid_q;
    assign level          = level_q;
    assign overflow       = overflow_q;
    assign accepted_count = acc_q;
    assign dropped_count  = drop_q;

endmodule

// File: tb/tb_char_stream_feeder.sv
// Directed bench for char_stream_feeder.
// Captures handshake transfers and compares against hand-written byte lists.
module tb_char_stream_feeder;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        ds_ready;
    logic        flush;
    logic [4:0]  level;
    logic        overflow;
    logic [15:0] accepted_count;
    logic [15:0] dropped_count;

    int n_chk  = 0;
    int n_fail = 0;
    logic       mon_en = 1'b0;
    logic [7:0] gotq[$];
    logic [7:0] expq[$];

    char_stream_feeder #(
        .DEPTH     (16),
        .ADDR_W    (4),
        .DROP_CTRL (1'b1)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .ds_ready       (ds_ready),
        .flush          (flush),
        .level          (level),
        .overflow       (overflow),
        .accepted_count (accepted_count),
        .dropped_count  (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 ns after posedge, so a negedge sample predicts the transfer.
    always @(negedge clk) begin
        if (mon_en && out_valid && ds_ready) gotq.push_back(out_data);
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
    endtask

    task automatic cmp_q(input string tag);
        int n;
        check({tag, "_cnt"}, gotq.size(), expq.size());
        n = (gotq.size() < expq.size()) ? gotq.size() : expq.size();
        for (int i = 0; i < n; i++) check({tag, "_byte"}, gotq[i], expq[i]);
        gotq.delete();
        expq.delete();
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        ds_ready = 1'b0;
        flush    = 1'b0;
        step();
        step();
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_level", level, 0);
        check("rst_ready", in_ready, 1);
        check("rst_ovf", overflow, 0);
        check("rst_acc", accepted_count, 0);
        check("rst_drop", dropped_count, 0);
        rst = 1'b0;
        step();

        // "a@b." streamed with ds_ready high
        ds_ready = 1'b1;
        mon_en   = 1'b1;
        push(8'h61);
        check("lat_n1_valid", out_valid, 0);
        push(8'h40);
        check("lat_n2_valid", out_valid, 1);
        check("lat_n2_data", out_data, 8'h61);
        push(8'h62);
        push(8'h2E);
        in_valid = 1'b0;
        repeat (5) step();
        expq = '{8'h61, 8'h40, 8'h62, 8'h2E};
        cmp_q("abdot");
        check("abdot_acc", accepted_count, 4);
        check("abdot_idle", out_valid, 0);

        // fill to full with ds_ready low, then offer one more
        ds_ready = 1'b0;
        for (int i = 0; i < 17; i++) push(8'h41 + 8'(i));
        in_valid = 1'b0;
        check("full_level", level, 16);
        check("full_ready", in_ready, 0);
        check("full_ovf0", overflow, 0);
        check("full_hold", out_data, 8'h41);
        check("full_valid", out_valid, 1);
        push(8'h5A);
        in_valid = 1'b0;
        check("ovf_set", overflow, 1);
        check("ovf_level", level, 16);
        check("ovf_hold", out_data, 8'h41);
        check("ovf_acc", accepted_count, 21);
        ds_ready = 1'b1;
        repeat (22) step();
        for (int i = 0; i < 17; i++) expq.push_back(8'h41 + 8'(i));
        cmp_q("drain");
        check("drain_level", level, 0);

        // control-byte filtering
        push(8'h31);
        push(8'h0A);
        push(8'h32);
        push(8'h7F);
        in_valid = 1'b0;
        repeat (5) step();
        expq = '{8'h31, 8'h32};
        cmp_q("filt");
        check("filt_acc", accepted_count, 23);
        check("filt_drop", dropped_count, 2);

        // downstream ready toggling every cycle
        for (int i = 0; i < 8; i++) begin
            ds_ready = (i % 2 == 0);
            push(8'h30 + 8'(i));
        end
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            ds_ready = (i % 2 == 0);
            step();
        end
        for (int i = 0; i < 8; i++) expq.push_back(8'h30 + 8'(i));
        cmp_q("toggle");
        check("toggle_acc", accepted_count, 31);

        // flush at level 5 with a simultaneous push
        ds_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
        in_valid = 1'b0;
        check("pre_flush_level", level, 5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h70;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_level", level, 0);
        check("flush_valid", out_valid, 0);
        check("flush_acc", accepted_count, 37);
        check("flush_ovf", overflow, 1);
        check("flush_drop", dropped_count, 2);
        ds_ready = 1'b1;
        repeat (3) step();
        check("flush_quiet", out_valid, 0);
        cmp_q("flush_none");

        // asynchronous reset mid-stream
        mon_en   = 1'b0;
        ds_ready = 1'b0;
        push(8'h61);
        push(8'h62);
        push(8'h63);
        in_valid = 1'b0;
        check("pre_rst_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_level", level, 0);
        check("arst_ovf", overflow, 0);
        check("arst_acc", accepted_count, 0);
        check("arst_drop", dropped_count, 0);
        step();
        rst      = 1'b0;
        ds_ready = 1'b1;
        mon_en   = 1'b1;
        step();
        push(8'h7A);
        in_valid = 1'b0;
        repeat (4) step();
        expq = '{8'h7A};
        cmp_q("post_rst");
        check("post_rst_acc", accepted_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
